seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 64 ++++++
 tb/tb_seq_multiplier.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, one multiplier bit per enabled cycle,
// unsigned or two's complement operands, valid/ready on both sides.
module seq_multiplier #(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       sgn,
   input  logic [WIDTH_A-1:0]         a,
   input  logic [WIDTH_B-1:0]         b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic [WIDTH_A+WIDTH_B-1:0] m
);
   localparam int W  = WIDTH_A + WIDTH_B;
   localparam int CW = $clog2(WIDTH_B);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0] acc, pp;
   logic [WIDTH_A-1:0] a_r;
   logic [WIDTH_B-1:0] b_r;
   logic sgn_r, last;
   always_comb begin
      last = cnt == CW'(WIDTH_B - 1);
      pp = {{WIDTH_B{sgn_r & a_r[WIDTH_A-1]}}, a_r} << cnt;
      state_nxt = !en ? state :
                  (state == IDLE && in_valid) ? BUSY :
                  (state == BUSY && last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         acc <= '0;
         a_r <= '0;
         b_r <= '0;
         sgn_r <= 1'b0;
      end else if (en) begin
         if (state == IDLE && in_valid) begin
            cnt <= '0;
            acc <= '0;
            a_r <= a;
            b_r <= b;
            sgn_r <= sgn;
         end else if (state == BUSY) begin
            // signed MSB of b carries weight -2^(WIDTH_B-1)
            if (b_r[cnt]) acc <= (sgn_r && last) ? acc - pp : acc + pp;
            cnt <= cnt + CW'(1);
         end
      end
   assign in_ready  = state == IDLE;
   assign busy      = state == BUSY;
   assign out_valid = state == DONE;
   assign m         = acc;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench; expected products come from plain integer
// multiplication of the issued operands, checked whenever the DUT presents out_valid.
module tb_seq_multiplier;
   logic clk = 0, rst = 1, en = 1, in_valid = 0, out_ready = 1, sgn = 0;
   logic [7:0] a = 0, b = 0;
   logic in_ready, out_valid, busy;
   logic [15:0] m;
   logic [15:0] q[$];
   int checks = 0, failures = 0;
   logic [15:0] mv;
   int e, n;
   bit rnd_done;

   seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .sgn(sgn), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .m(m)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] x, input logic [7:0] y);
      longint sx = s ? longint'($signed(x)) : longint'(x);
      longint sy = s ? longint'($signed(y)) : longint'(y);
      return 16'(sx * sy);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // returns number of edges waited until accept
   task automatic send(input logic s, input logic [7:0] x, input logic [7:0] y, output int cnt);
      bit acc = 0;
      sgn = s; a = x; b = y; in_valid = 1;
      cnt = 0;
      while (!acc && cnt < 200) begin
         @(negedge clk);
         acc = in_ready && en;
         if (acc) q.push_back(ref_mul(s, x, y));
         @(posedge clk);
         #2;
         cnt++;
      end
      in_valid = 0;
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!out_valid && cnt < 100);
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         chk("dv_flags", {30'd0, in_ready, busy}, 0);
         if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
         else begin
            chk("product", m, q[0]);
            if (en && out_ready) void'(q.pop_front());
         end
      end
   end

   typedef struct { logic s; logic [7:0] x, y; logic [15:0] p; } vec_t;
   vec_t vecs[6] = '{
      '{0, 8'hFF, 8'hFF, 16'hFE01}, '{1, 8'h80, 8'h80, 16'h4000},
      '{1, 8'hFF, 8'h7F, 16'hFF81}, '{1, 8'h7F, 8'h80, 16'hC080},
      '{0, 8'h00, 8'hA5, 16'h0000}, '{1, 8'h5A, 8'h00, 16'h0000}};

   initial begin
      #3;
      chk("reset_outputs", {in_ready, busy, out_valid, 13'd0, m}, {1'b1, 2'b00, 13'd0, 16'h0});
      step();
      step();
      rst = 0;
      send(0, 8'h21, 8'h43, n);
      chk("first_edge_accept", n, 1);
      wait_done(e);
      chk("latency_first", e, 8);
      step();
      foreach (vecs[i]) begin
         send(vecs[i].s, vecs[i].x, vecs[i].y, n);
         wait_done(e);
         chk($sformatf("latency_%0d", i), e, 8);
         chk($sformatf("const_%0d", i), m, vecs[i].p);
         step();
         chk($sformatf("idle_after_%0d", i), {in_ready, out_valid}, 2'b10);
      end
      // back-pressure, plus no accept on the handshake edge
      out_ready = 0;
      send(0, 8'h12, 8'h34, n);
      wait_done(e);
      mv = m;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold", {in_ready, out_valid, m}, {2'b01, mv});
      end
      a = 8'h55; b = 8'h66; in_valid = 1; out_ready = 1;
      step();
      chk("bp_release", {in_ready, busy, out_valid}, 3'b100);
      in_valid = 0;
      step();
      chk("no_accept_on_handshake", {in_ready, busy}, 2'b10);
      // operand changes during BUSY are ignored
      send(1, 8'hC3, 8'h5D, n);
      step(); step();
      a = 8'h11; b = 8'h22; sgn = 0; in_valid = 1;
      step();
      in_valid = 0;
      wait_done(e);
      chk("ignore_latency", 3 + e, 8);
      step();
      // stall for three cycles mid-operation
      send(0, 8'hB7, 8'hE9, n);
      step(); step();
      en = 0;
      step(); step(); step();
      chk("stall_frozen", {busy, out_valid}, 2'b10);
      en = 1;
      wait_done(e);
      chk("stall_latency", 5 + e, 11);
      step();
      // reset at k=4
      send(0, 8'h77, 8'h99, n);
      repeat (4) step();
      rst = 1;
      #1;
      chk("mid_reset", {in_ready, busy, out_valid, 13'd0, m}, {1'b1, 2'b00, 13'd0, 16'h0});
      q.delete();
      step();
      rst = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("no_valid_after_reset", {in_ready, out_valid}, 2'b10);
      end
      send(0, 8'd3, 8'd5, n);
      wait_done(e);
      chk("post_reset_latency", e, 8);
      chk("post_reset_product", m, 16'd15);
      step();
      // randomised with random en and out_ready
      rnd_done = 0;
      fork
         while (!rnd_done) begin
            @(posedge clk);
            #1;
            en = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 1) == 1;
         end
         begin
            for (int i = 0; i < 40; i++)
               send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), n);
            e = 0;
            while (q.size() != 0 && e < 2000) begin
               step();
               e++;
            end
            chk("random_drain", q.size(), 0);
            rnd_done = 1;
         end
      join
      en = 1;
      out_ready = 1;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
